seq_mlp_engine: RTL and testbench

- Time-multiplexed, parametrised 2-layer MLP classifier for printed-electronics targets.
- Evaluates NUM_IN→NUM_HID→NUM_OUT with a single shared MAC instead of a fully parallel combinational datapath.
- Hidden layer: ReLU plus requantisation. Output layer: running argmax.
- Sits between the sample source and the classification sink, with valid/ready handshakes on both sides. Weights and biases come in as flat packed buses.

---
 rtl/seq_mlp_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_seq_mlp_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mlp_engine.sv
`default_nettype none
// ============================================================================
// Module      : seq_mlp_engine
// Description : Time-multiplexed two-layer MLP classifier built around one
//               shared multiply-accumulate unit.
//               Layer 0 computes NUM_IN -> NUM_HID with ReLU, a right shift
//               and saturation. Layer 1 computes NUM_HID -> NUM_OUT and keeps
//               a running argmax, so only the winning class survives.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               inp        - packed unsigned input features
//               in_valid   - input sample valid
//               in_ready   - engine idle and able to accept a sample
//               weights    - packed signed weights (layer 0, then layer 1)
//               biases     - packed signed biases (b0 block, then b1 block)
//               out        - winning class index
//               out_score  - accumulator value of the winning class
//               out_valid  - out/out_score valid
//               out_ready  - sink accepts the result
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mlp_engine #(
  parameter int NUM_IN   = 16,
  parameter int WIDTH_A  = 4,
  parameter int NUM_HID  = 3,
  parameter int NUM_OUT  = 10,
  parameter int WIDTH_W  = 8,
  parameter int WIDTH_B0 = 9,
  parameter int WIDTH_B1 = 15,
  parameter int WIDTH_H  = 8,
  parameter int SHIFT0   = 4,
  parameter int ACC_W    = 24,
  parameter int OUTWIDTH = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [NUM_IN*WIDTH_A-1:0]                            inp,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [(NUM_HID*NUM_IN+NUM_OUT*NUM_HID)*WIDTH_W-1:0]  weights,
  input  logic [NUM_HID*WIDTH_B0+NUM_OUT*WIDTH_B1-1:0]         biases,
  output logic [OUTWIDTH-1:0]                                  out,
  output logic [ACC_W-1:0]                                     out_score,
  output logic                                                 out_valid,
  input  logic                                                 out_ready
);

  localparam int NUM_W  = NUM_HID*NUM_IN + NUM_OUT*NUM_HID;
  localparam int IW     = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int HW     = (NUM_HID > 1) ? $clog2(NUM_HID) : 1;
  localparam int OW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int WIDX_W = (NUM_W   > 1) ? $clog2(NUM_W)   : 1;
  localparam logic [WIDTH_H-1:0] C_H_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L0   = 2'd1,
    S_L1   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                      state_q;
  logic [NUM_IN*WIDTH_A-1:0]   x_q;
  logic signed [ACC_W-1:0]     acc_q;
  logic [IW-1:0]               i_q;
  logic [HW-1:0]               j_q;
  logic [OW-1:0]               o_q;
  logic [WIDTH_H-1:0]          h_q [NUM_HID];
  logic signed [ACC_W-1:0]     best_q;
  logic [OUTWIDTH-1:0]         best_idx_q;
  logic                        fin_q;      // all outputs scored, commit pending
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [OUTWIDTH-1:0]         out_q;
  logic [ACC_W-1:0]            out_score_q;

  // --------------------------------------------------------------------------
  // Unpacked views of the flat buses
  // --------------------------------------------------------------------------
  logic [WIDTH_A-1:0]          x_arr  [NUM_IN];
  logic [WIDTH_W-1:0]          w_arr  [NUM_W];
  logic signed [ACC_W-1:0]     b0_ext [NUM_HID];
  logic signed [ACC_W-1:0]     b1_ext [NUM_OUT];

  generate
    for (genvar g = 0; g < NUM_IN; g++) begin : g_x
      assign x_arr[g] = x_q[g*WIDTH_A +: WIDTH_A];
    end
    for (genvar g = 0; g < NUM_W; g++) begin : g_w
      assign w_arr[g] = weights[g*WIDTH_W +: WIDTH_W];
    end
    for (genvar g = 0; g < NUM_HID; g++) begin : g_b0
      assign b0_ext[g] = {{(ACC_W-WIDTH_B0){biases[g*WIDTH_B0 + WIDTH_B0 - 1]}},
                          biases[g*WIDTH_B0 +: WIDTH_B0]};
    end
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_b1
      assign b1_ext[g] = {{(ACC_W-WIDTH_B1){biases[NUM_HID*WIDTH_B0 + g*WIDTH_B1 + WIDTH_B1 - 1]}},
                          biases[NUM_HID*WIDTH_B0 + g*WIDTH_B1 +: WIDTH_B1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shared MAC datapath
  // --------------------------------------------------------------------------
  logic [WIDX_W-1:0]           w_widx;
  logic signed [ACC_W-1:0]     w_opa;
  logic signed [ACC_W-1:0]     w_opw;
  logic signed [ACC_W-1:0]     acc_d;
  logic [ACC_W-1:0]            w_sh;
  logic [WIDTH_H-1:0]          w_hval;
  logic                        w_last_i;
  logic                        w_last_j;
  logic                        w_last_o;
  logic [HW-1:0]               w_jn;
  logic [OW-1:0]               w_on;
  logic                        w_take;

  always_comb begin
    if (state_q == S_L1) begin
      w_widx = WIDX_W'(NUM_HID*NUM_IN + int'(o_q)*NUM_HID + int'(j_q));
      w_opa  = ACC_W'(h_q[j_q]);
    end else begin
      w_widx = WIDX_W'(int'(j_q)*NUM_IN + int'(i_q));
      w_opa  = ACC_W'(x_arr[i_q]);
    end
  end

  assign w_opw = {{(ACC_W-WIDTH_W){w_arr[w_widx][WIDTH_W-1]}}, w_arr[w_widx]};
  assign acc_d = acc_q + w_opa * w_opw;

  // ReLU, shift, saturate. The shift is only used when acc_d is non-negative,
  // so a logical shift is sufficient.
  assign w_sh = acc_d >> SHIFT0;
  always_comb begin
    if (acc_d[ACC_W-1]) begin
      w_hval = '0;
    end else if (w_sh > {{(ACC_W-WIDTH_H){1'b0}}, C_H_MAX}) begin
      w_hval = C_H_MAX;
    end else begin
      w_hval = w_sh[WIDTH_H-1:0];
    end
  end

  assign w_last_i = (i_q == IW'(NUM_IN-1));
  assign w_last_j = (j_q == HW'(NUM_HID-1));
  assign w_last_o = (o_q == OW'(NUM_OUT-1));
  // Next-neuron indices wrap to 0 so the bias arrays are never over-indexed.
  assign w_jn     = w_last_j ? '0 : j_q + HW'(1);
  assign w_on     = w_last_o ? '0 : o_q + OW'(1);
  // Strict greater-than: ties keep the lower class index.
  assign w_take   = (o_q == '0) || (acc_d > best_q);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      o_q         <= '0;
      for (int k = 0; k < NUM_HID; k++) h_q[k] <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      fin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_score_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= inp;
            acc_q      <= b0_ext[0];
            i_q        <= '0;
            j_q        <= '0;
            o_q        <= '0;
            fin_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_L0;
          end
        end

        S_L0: begin
          acc_q <= acc_d;
          if (w_last_i) begin
            h_q[j_q] <= w_hval;
            i_q      <= '0;
            j_q      <= w_jn;
            if (w_last_j) begin
              acc_q   <= b1_ext[0];
              state_q <= S_L1;
            end else begin
              acc_q   <= b0_ext[w_jn];
            end
          end else begin
            i_q <= i_q + IW'(1);
          end
        end

        S_L1: begin
          if (fin_q) begin
            out_q       <= best_idx_q;
            out_score_q <= best_q;
            out_valid_q <= 1'b1;
            fin_q       <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            acc_q <= acc_d;
            if (w_last_j) begin
              j_q <= '0;
              if (w_take) begin
                best_q     <= acc_d;
                best_idx_q <= OUTWIDTH'(o_q);
              end
              o_q   <= w_on;
              acc_q <= b1_ext[w_on];
              if (w_last_o) fin_q <= 1'b1;
            end else begin
              j_q <= j_q + HW'(1);
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_score = out_score_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mlp_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mlp_engine
// Description : Self-checking bench for seq_mlp_engine. Directed vectors in a
//               table, hand-written backpressure and mid-run reset sequences,
//               and random samples scored by an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mlp_engine;

  localparam int NUM_IN   = 16;
  localparam int WIDTH_A  = 4;
  localparam int NUM_HID  = 3;
  localparam int NUM_OUT  = 10;
  localparam int WIDTH_W  = 8;
  localparam int WIDTH_B0 = 9;
  localparam int WIDTH_B1 = 15;
  localparam int WIDTH_H  = 8;
  localparam int SHIFT0   = 4;
  localparam int ACC_W    = 24;
  localparam int OUTWIDTH = 4;
  localparam int NUM_W    = NUM_HID*NUM_IN + NUM_OUT*NUM_HID;
  localparam int W_BITS   = NUM_W*WIDTH_W;
  localparam int B_BITS   = NUM_HID*WIDTH_B0 + NUM_OUT*WIDTH_B1;
  localparam int X_BITS   = NUM_IN*WIDTH_A;
  localparam int LATENCY  = NUM_HID*NUM_IN + NUM_OUT*NUM_HID + 1;

  typedef struct {
    logic [X_BITS-1:0] x;
    logic [W_BITS-1:0] w;
    logic [B_BITS-1:0] b;
    int                hold;
    int                exp_cls;
    int                exp_score;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic [X_BITS-1:0]   inp;
  logic                in_valid;
  logic                in_ready;
  logic [W_BITS-1:0]   weights;
  logic [B_BITS-1:0]   biases;
  logic [OUTWIDTH-1:0] out;
  logic [ACC_W-1:0]    out_score;
  logic                out_valid;
  logic                out_ready;

  int checks   = 0;
  int failures = 0;

  logic [W_BITS-1:0] tw;
  logic [B_BITS-1:0] tbias;
  vec_t              tbl [5];

  seq_mlp_engine #(
    .NUM_IN(NUM_IN), .WIDTH_A(WIDTH_A), .NUM_HID(NUM_HID), .NUM_OUT(NUM_OUT),
    .WIDTH_W(WIDTH_W), .WIDTH_B0(WIDTH_B0), .WIDTH_B1(WIDTH_B1),
    .WIDTH_H(WIDTH_H), .SHIFT0(SHIFT0), .ACC_W(ACC_W), .OUTWIDTH(OUTWIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid),
    .in_ready(in_ready), .weights(weights), .biases(biases), .out(out),
    .out_score(out_score), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_w(input int k, input int v);
    tw[k*WIDTH_W +: WIDTH_W] = WIDTH_W'(v);
  endtask

  task automatic set_b0(input int j, input int v);
    tbias[j*WIDTH_B0 +: WIDTH_B0] = WIDTH_B0'(v);
  endtask

  task automatic set_b1(input int o, input int v);
    tbias[NUM_HID*WIDTH_B0 + o*WIDTH_B1 +: WIDTH_B1] = WIDTH_B1'(v);
  endtask

  // Reference model: plain integer arithmetic on the packed buses.
  function automatic void model(input logic [W_BITS-1:0] w,
                                input logic [B_BITS-1:0] b,
                                input logic [X_BITS-1:0] x,
                                output int cls, output int score);
    int h [NUM_HID];
    int acc;
    for (int j = 0; j < NUM_HID; j++) begin
      acc = int'($signed(b[j*WIDTH_B0 +: WIDTH_B0]));
      for (int i = 0; i < NUM_IN; i++)
        acc += int'(x[i*WIDTH_A +: WIDTH_A]) *
               int'($signed(w[(j*NUM_IN+i)*WIDTH_W +: WIDTH_W]));
      if (acc < 0) h[j] = 0;
      else         h[j] = acc / (1 << SHIFT0);
      if (h[j] > (1 << WIDTH_H) - 1) h[j] = (1 << WIDTH_H) - 1;
    end
    cls = 0;
    score = 0;
    for (int o = 0; o < NUM_OUT; o++) begin
      acc = int'($signed(b[NUM_HID*WIDTH_B0 + o*WIDTH_B1 +: WIDTH_B1]));
      for (int j = 0; j < NUM_HID; j++)
        acc += h[j] * int'($signed(w[(NUM_HID*NUM_IN + o*NUM_HID + j)*WIDTH_W +: WIDTH_W]));
      if (o == 0 || acc > score) begin
        cls = o;
        score = acc;
      end
    end
  endfunction

  // One complete transaction: accept, time the latency, check the result,
  // optionally stall the sink while disturbing the inputs, then drain.
  task automatic run_sample(input vec_t v);
    int cnt;
    @(negedge clk);
    inp = v.x; weights = v.w; biases = v.b; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", int'(in_ready), 0);
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (out_valid) break;
      // Disturb the sample inputs while busy; they must be ignored.
      inp = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("latency", cnt, LATENCY);
    check("out", int'(out), v.exp_cls);
    check("out_score", int'($signed(out_score)), v.exp_score);
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_out", int'(out), v.exp_cls);
      check("hold_score", int'($signed(out_score)), v.exp_score);
      inp = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_valid", int'(out_valid), 0);
    check("drain_in_ready", int'(in_ready), 1);
    check("drain_out", int'(out), v.exp_cls);
    check("drain_score", int'($signed(out_score)), v.exp_score);
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0; inp = '0; in_valid = 1'b0; weights = '0; biases = '0;
    out_ready = 1'b0;

    // Directed vectors
    tw = '0; tbias = '0; set_b1(7, 100);
    tbl[0] = '{x: {$urandom, $urandom}, w: tw, b: tbias, hold: 0, exp_cls: 7, exp_score: 100};
    tw = '0; tbias = '0;
    tbl[1] = '{x: {$urandom, $urandom}, w: tw, b: tbias, hold: 1, exp_cls: 0, exp_score: 0};
    tw = '0; tbias = '0;
    for (int k = 0; k < NUM_HID*NUM_IN; k++) set_w(k, 127);
    set_w(NUM_HID*NUM_IN + 3*NUM_HID + 0, 1);
    tbl[2] = '{x: '1, w: tw, b: tbias, hold: 0, exp_cls: 3, exp_score: 255};
    tw = '0; tbias = '0;
    for (int j = 0; j < NUM_HID; j++) set_b0(j, -500);
    for (int o = 0; o < NUM_OUT; o++) set_b1(o, -9);
    set_b1(0, -5); set_b1(1, -5); set_b1(2, -2);
    tbl[3] = '{x: '1, w: tw, b: tbias, hold: 2, exp_cls: 2, exp_score: -2};
    // Tie between classes 1 and 2 keeps the lower index; long sink stall.
    tw = '0; tbias = '0;
    set_b1(0, 3); set_b1(1, 5); set_b1(2, 5); set_b1(9, -1);
    tbl[4] = '{x: {$urandom, $urandom}, w: tw, b: tbias, hold: 10, exp_cls: 1, exp_score: 5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    check("rst_score", int'(out_score), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) run_sample(tbl[t]);

    // Reset 20 cycles into layer 0 aborts the run and restores reset values.
    @(negedge clk);
    inp = '1; weights = tbl[2].w; biases = tbl[2].b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out", int'(out), 0);
    check("abort_score", int'(out_score), 0);
    repeat (LATENCY) @(posedge clk);
    #1;
    check("abort_hold_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(tbl[3]);

    // Random samples against the model
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NUM_W; k++) rv.w[k*WIDTH_W +: WIDTH_W] = WIDTH_W'($urandom);
      for (int k = 0; k < B_BITS; k++) rv.b[k] = 1'($urandom);
      rv.x = {$urandom, $urandom};
      rv.hold = $urandom_range(0, 3);
      model(rv.w, rv.b, rv.x, rv.exp_cls, rv.exp_score);
      run_sample(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
